// File: rtl/miner_pkg.sv
// Shared constants for the proof-of-work miner: SHA-256 round constants and IV,
// register map, control codes, status encoding and the SHA-256 logic functions.
package miner_pkg;

  typedef enum logic [2:0] {
    STAT_IDLE      = 3'd0,
    STAT_READY     = 3'd1,
    STAT_MINING    = 3'd2,
    STAT_FOUND     = 3'd3,
    STAT_EXHAUSTED = 3'd4
  } status_t;

  localparam logic [4:0] ADDR_STATUS    = 5'd0;
  localparam logic [4:0] ADDR_CONTROL   = 5'd1;
  localparam logic [4:0] ADDR_TARGET_LO = 5'd2;
  localparam logic [4:0] ADDR_TARGET_HI = 5'd9;
  localparam logic [4:0] ADDR_NONCE     = 5'd10;
  localparam logic [4:0] ADDR_MSG_LO    = 5'd11;
  localparam logic [4:0] ADDR_MSG_HI    = 5'd29;

  localparam logic [31:0] CTRL_ABORT = 32'd0;
  localparam logic [31:0] CTRL_READY = 32'd1;
  localparam logic [31:0] CTRL_START = 32'd2;

  localparam logic [255:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  function automatic logic [31:0] sha_ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] sha_maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: 1 load cycle, 64 round cycles, 1 add cycle.
// The message schedule is generated on the fly in a 16-word sliding window.
module sha256_compress
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [255:0] chain_in,
  input  logic [511:0] block_in,
  output logic [255:0] digest,
  output logic         done
);

  // Handshake: start is a one-cycle request that loads chain_in/block_in on
  // its edge (restarting any compression in flight); done is high for exactly
  // one cycle, the add cycle, and digest is valid only while done is high.
  logic         busy;
  logic [6:0]   rnd;
  logic [31:0]  v [8];
  logic [31:0]  w [16];
  logic [255:0] chain_q;
  logic [31:0]  t1, t2, w_next;

  always_comb begin
    t1     = v[7] + big_sigma1(v[4]) + sha_ch(v[4], v[5], v[6]) + SHA_K[rnd[5:0]] + w[0];
    t2     = big_sigma0(v[0]) + sha_maj(v[0], v[1], v[2]);
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  assign done = busy && rnd[6];

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++)
      digest[255 - 32*i -: 32] = chain_q[255 - 32*i -: 32] + v[i];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      busy    <= 1'b0;
      rnd     <= 7'd0;
      chain_q <= '0;
      for (int i = 0; i < 8; i++)  v[i] <= 32'd0;
      for (int i = 0; i < 16; i++) w[i] <= 32'd0;
    end else if (start) begin
      busy    <= 1'b1;
      rnd     <= 7'd0;
      chain_q <= chain_in;
      for (int i = 0; i < 8; i++)  v[i] <= chain_in[255 - 32*i -: 32];
      for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
    end else if (busy) begin
      if (rnd[6]) begin
        busy <= 1'b0;
      end else begin
        rnd  <= rnd + 7'd1;
        v[0] <= t1 + t2;
        v[1] <= v[0];
        v[2] <= v[1];
        v[3] <= v[2];
        v[4] <= v[3] + t1;
        v[5] <= v[4];
        v[6] <= v[5];
        v[7] <= v[6];
        // w[0] always holds W[t] for the round being computed.
        for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
        w[15] <= w_next;
      end
    end
  end

endmodule

// File: rtl/top_level_miner.sv
// Memory-mapped double-SHA-256 proof-of-work engine. Defining MINER_MIDSTATE_EN
// caches the first-block midstate so each nonce costs 132 instead of 198 cycles.
module top_level_miner
  import miner_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [4:0]  slaveAddr,
  input  logic [31:0] slaveWriteData,
  input  logic        slaveWrite,
  input  logic        slaveRead,
  input  logic        slaveChipSelect,
  output logic [31:0] slaveReadData
);

  localparam logic [2:0] FSM_IDLE      = 3'd0;
  localparam logic [2:0] FSM_READY     = 3'd1;
  localparam logic [2:0] FSM_MID       = 3'd2;
  localparam logic [2:0] FSM_BLK2      = 3'd3;
  localparam logic [2:0] FSM_HASH2     = 3'd4;
  localparam logic [2:0] FSM_FOUND     = 3'd5;
  localparam logic [2:0] FSM_EXHAUSTED = 3'd6;

  logic [2:0]   fsm_state;
  logic         launch;
  logic [31:0]  nonce;
  logic [31:0]  target_w [8];
  logic [31:0]  msg_w [19];
  logic [255:0] target;
  logic [607:0] msg;
  logic [255:0] midstate, hash1;
  logic [255:0] comp_chain, comp_digest;
  logic [511:0] comp_block;
  logic         comp_done;
  logic         mining, wr_en, rd_en, ctrl_wr;
  logic         ctrl_abort, ctrl_ready, ctrl_start;
  logic         step, hit;
  logic         in_target, in_msg;
  logic [2:0]   tgt_off;
  logic [4:0]   msg_off;
  status_t      status;
  logic [31:0]  rd_mux;

  always_comb begin
    target = '0;
    msg    = '0;
    for (int i = 0; i < 8; i++)  target[32*i +: 32] = target_w[i];
    for (int i = 0; i < 19; i++) msg[32*i +: 32]    = msg_w[i];
  end

  assign mining     = (fsm_state == FSM_MID) || (fsm_state == FSM_BLK2) || (fsm_state == FSM_HASH2);
  assign wr_en      = slaveChipSelect && slaveWrite;
  assign rd_en      = slaveChipSelect && slaveRead;
  assign ctrl_wr    = wr_en && (slaveAddr == ADDR_CONTROL);
  assign ctrl_abort = ctrl_wr && (slaveWriteData == CTRL_ABORT);
  assign ctrl_ready = ctrl_wr && (slaveWriteData == CTRL_READY);
  assign ctrl_start = ctrl_wr && (slaveWriteData == CTRL_START) &&
                      ((fsm_state == FSM_READY) || (fsm_state == FSM_FOUND) ||
                       (fsm_state == FSM_EXHAUSTED));

  assign in_target = (slaveAddr >= ADDR_TARGET_LO) && (slaveAddr <= ADDR_TARGET_HI);
  assign in_msg    = (slaveAddr >= ADDR_MSG_LO) && (slaveAddr <= ADDR_MSG_HI);
  // Addresses 2..9 wrap modulo 8 onto word indices 0..7.
  assign tgt_off   = slaveAddr[2:0] - 3'd2;
  assign msg_off   = slaveAddr - ADDR_MSG_LO;

  always_comb begin
    comp_chain = SHA_IV;
    comp_block = msg[607:96];
    case (fsm_state)
      FSM_BLK2: begin
        comp_chain = midstate;
        comp_block = {msg[95:0], nonce, 32'h8000_0000, 288'd0, 64'd640};
      end
      FSM_HASH2: begin
        comp_chain = SHA_IV;
        comp_block = {hash1, 32'h8000_0000, 160'd0, 64'd256};
      end
      default: ;
    endcase
  end

  sha256_compress u_compress (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (launch),
    .chain_in (comp_chain),
    .block_in (comp_block),
    .digest   (comp_digest),
    .done     (comp_done)
  );

  // A done from a compression that was superseded by a fresh launch is ignored.
  assign step = comp_done && !launch;
  assign hit  = comp_digest < target;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fsm_state <= FSM_IDLE;
      launch    <= 1'b0;
      nonce     <= 32'd0;
      midstate  <= '0;
      hash1     <= '0;
    end else begin
      launch <= 1'b0;
      if (ctrl_abort) begin
        fsm_state <= FSM_IDLE;
      end else if (ctrl_ready) begin
        fsm_state <= FSM_READY;
      end else if (ctrl_start) begin
        fsm_state <= FSM_MID;
        nonce     <= 32'd0;
        launch    <= 1'b1;
      end else if (step) begin
        case (fsm_state)
          FSM_MID: begin
            midstate  <= comp_digest;
            fsm_state <= FSM_BLK2;
            launch    <= 1'b1;
          end
          FSM_BLK2: begin
            hash1     <= comp_digest;
            fsm_state <= FSM_HASH2;
            launch    <= 1'b1;
          end
          FSM_HASH2: begin
            if (hit) begin
              fsm_state <= FSM_FOUND;
            end else if (nonce == 32'hFFFF_FFFF) begin
              fsm_state <= FSM_EXHAUSTED;
            end else begin
              nonce  <= nonce + 32'd1;
              launch <= 1'b1;
`ifdef MINER_MIDSTATE_EN
              fsm_state <= FSM_BLK2;
`else
              fsm_state <= FSM_MID;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < 8; i++)  target_w[i] <= 32'd0;
      for (int i = 0; i < 19; i++) msg_w[i]    <= 32'd0;
    end else if (wr_en && !mining) begin
      if (in_target)   target_w[tgt_off] <= slaveWriteData;
      else if (in_msg) msg_w[msg_off]    <= slaveWriteData;
    end
  end

  always_comb begin
    case (fsm_state)
      FSM_READY:                     status = STAT_READY;
      FSM_MID, FSM_BLK2, FSM_HASH2:  status = STAT_MINING;
      FSM_FOUND:                     status = STAT_FOUND;
      FSM_EXHAUSTED:                 status = STAT_EXHAUSTED;
      default:                       status = STAT_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    if (slaveAddr == ADDR_STATUS)     rd_mux = {29'd0, status};
    else if (slaveAddr == ADDR_NONCE) rd_mux = nonce;
    else if (in_target)               rd_mux = target_w[tgt_off];
    else if (in_msg)                  rd_mux = msg_w[msg_off];
  end

  always_ff @(posedge clk) begin
    if (!n_rst)     slaveReadData <= 32'd0;
    else if (rd_en) slaveReadData <= rd_mux;
  end

endmodule

// File: tb/tb_top_level_miner.sv
// Directed bench for top_level_miner: register map, control actions, exact
// first-result latency, per-nonce spacing, abort/reset and a model-checked search.
module tb_top_level_miner;
  import miner_pkg::*;

`ifdef MINER_MIDSTATE_EN
  localparam int NONCE_CYCLES = 132;
`else
  localparam int NONCE_CYCLES = 198;
`endif

  logic        clk;
  logic        n_rst;
  logic [4:0]  slaveAddr;
  logic [31:0] slaveWriteData;
  logic        slaveWrite;
  logic        slaveRead;
  logic        slaveChipSelect;
  logic [31:0] slaveReadData;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q [$];

  top_level_miner dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .slaveAddr       (slaveAddr),
    .slaveWriteData  (slaveWriteData),
    .slaveWrite      (slaveWrite),
    .slaveRead       (slaveRead),
    .slaveChipSelect (slaveChipSelect),
    .slaveReadData   (slaveReadData)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    slaveChipSelect = 1'b0;
    slaveWrite      = 1'b0;
    slaveRead       = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    slaveChipSelect = 1'b1;
    slaveWrite      = 1'b1;
    slaveRead       = 1'b0;
    slaveAddr       = addr;
    slaveWriteData  = data;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    slaveChipSelect = 1'b1;
    slaveRead       = 1'b1;
    slaveWrite      = 1'b0;
    slaveAddr       = addr;
    @(negedge clk);
    bus_idle();
    data = slaveReadData;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_read(addr, rd);
    check_val(tag, rd, exp);
  endtask

  task automatic write_target(input logic [255:0] tgt);
    for (int a = 2; a <= 9; a++) bus_write(5'(a), tgt[32*(a-2) +: 32]);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] model_compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + SHA_K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] model_dsha(input logic [607:0] m, input logic [31:0] n);
    logic [255:0] mid, h1;
    mid = model_compress(SHA_IV, m[607:96]);
    h1  = model_compress(mid, {m[95:0], n, 32'h8000_0000, 288'd0, 64'd640});
    return model_compress(SHA_IV, {h1, 32'h8000_0000, 160'd0, 64'd256});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0]  rd;
    logic [255:0] tgt, dig;
    logic [607:0] msg;
    int           exp_n, found_k, budget;

    n_checks       = 0;
    n_errors       = 0;
    n_rst          = 1'b0;
    slaveAddr      = 5'd0;
    slaveWriteData = 32'd0;
    bus_idle();
    repeat (3) @(negedge clk);
    check_val("rdata_reset", slaveReadData, 32'd0);
    n_rst = 1'b1;

    // Every readable address reads zero out of reset.
    for (int a = 0; a < 30; a++) if (a != 1) exp_q.push_back(32'd0);
    for (int a = 0; a < 30; a++) begin
      if (a != 1) begin
        bus_read(5'(a), rd);
        check_val($sformatf("reset_rd_addr%0d", a), rd, exp_q.pop_front());
      end
    end

    // Start from IDLE is ignored.
    bus_write(ADDR_CONTROL, 32'd2);
    read_check("start_from_idle", ADDR_STATUS, 32'd0);

    // Register map, CONTROL 1, readback and hold behaviour.
    bus_write(5'd9, 32'h0100_0000);
    bus_write(ADDR_CONTROL, 32'd1);
    read_check("status_ready", ADDR_STATUS, 32'd1);
    read_check("target_hi_rd", 5'd9, 32'h0100_0000);
    repeat (3) @(negedge clk);
    check_val("rdata_hold", slaveReadData, 32'h0100_0000);
    read_check("target_lo_rd", 5'd2, 32'd0);
    bus_write(ADDR_CONTROL, 32'd7);
    read_check("ctrl_other_ignored", ADDR_STATUS, 32'd1);
    bus_write(5'd30, 32'hFFFF_FFFF);
    read_check("addr30_zero", 5'd30, 32'd0);
    read_check("addr31_zero", 5'd31, 32'd0);
    bus_write(5'd29, 32'hA5A5_0001);
    read_check("msg_hi_rd", 5'd29, 32'hA5A5_0001);
    bus_write(5'd29, 32'd0);

    // Known-answer check of the reference model: SHA-256("abc").
    dig = model_compress(SHA_IV, {24'h616263, 8'h80, 416'd0, 64'd24});
    check_val("model_abc", dig,
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    // Exact first-result latency: status flips on the 198th edge after start.
    tgt = '1;
    msg = '0;
    write_target(tgt);
    bus_write(ADDR_CONTROL, 32'd1);
    bus_write(ADDR_CONTROL, 32'd2);
    slaveChipSelect = 1'b1;
    slaveRead       = 1'b1;
    slaveAddr       = ADDR_STATUS;
    for (int c = 1; c <= 199; c++) begin
      @(negedge clk);
      if (c == 1)   check_val("status_mining", slaveReadData, 32'd2);
      if (c == 198) check_val("status_before_198", slaveReadData, 32'd2);
      if (c == 199) check_val("status_after_198", slaveReadData,
                              (model_dsha(msg, 32'd0) < tgt) ? 32'd3 : 32'd2);
    end
    bus_idle();
    read_check("nonce_zero_found", ADDR_NONCE, 32'd0);

    // Per-nonce spacing with an unreachable target, then write-ignore and abort.
    write_target('0);
    bus_write(ADDR_CONTROL, 32'd2);
    slaveChipSelect = 1'b1;
    slaveRead       = 1'b1;
    slaveAddr       = ADDR_NONCE;
    for (int c = 1; c <= 199 + NONCE_CYCLES; c++) begin
      @(negedge clk);
      if (c == 198)                check_val("nonce0_held", slaveReadData, 32'd0);
      if (c == 199)                check_val("nonce1_first", slaveReadData, 32'd1);
      if (c == 198 + NONCE_CYCLES) check_val("nonce1_held", slaveReadData, 32'd1);
      if (c == 199 + NONCE_CYCLES) check_val("nonce2_spacing", slaveReadData, 32'd2);
    end
    bus_idle();
    bus_write(5'd9, 32'hDEAD_BEEF);
    read_check("still_mining", ADDR_STATUS, 32'd2);
    repeat (600) @(negedge clk);
    bus_write(ADDR_CONTROL, 32'd0);
    read_check("abort_idle", ADDR_STATUS, 32'd0);
    read_check("target_write_ignored", 5'd9, 32'd0);

    // Reset while mining.
    bus_write(ADDR_MSG_LO, 32'h61);
    bus_write(ADDR_CONTROL, 32'd1);
    bus_write(ADDR_CONTROL, 32'd2);
    repeat (500) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check_val("rdata_after_reset", slaveReadData, 32'd0);
    read_check("reset_status", ADDR_STATUS, 32'd0);
    read_check("reset_nonce", ADDR_NONCE, 32'd0);
    read_check("reset_msg", ADDR_MSG_LO, 32'd0);
    repeat (300) @(negedge clk);
    read_check("reset_quiet", ADDR_STATUS, 32'd0);

    // Search against the software model; a looser target keeps the run short
    // if the first hit at the tight target lies far out.
    msg        = '0;
    msg[31:0]  = 32'h61;
    tgt        = {32'h0100_0000, 224'd0};
    exp_n      = -1;
    for (int n = 0; n < 250; n++) begin
      if (model_dsha(msg, 32'(n)) < tgt) begin exp_n = n; break; end
    end
    if (exp_n < 0) begin
      tgt = {32'h1000_0000, 224'd0};
      for (int n = 0; n < 250; n++) begin
        if (model_dsha(msg, 32'(n)) < tgt) begin exp_n = n; break; end
      end
    end
    check_val("model_search_hit", exp_n >= 0, 1'b1);
    if (exp_n < 0) exp_n = 0;

    bus_write(ADDR_MSG_LO, 32'h61);
    write_target(tgt);
    bus_write(ADDR_CONTROL, 32'd1);
    bus_write(ADDR_CONTROL, 32'd2);
    slaveChipSelect = 1'b1;
    slaveRead       = 1'b1;
    slaveAddr       = ADDR_STATUS;
    found_k = -1;
    budget  = 199 + exp_n * NONCE_CYCLES + 20;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (slaveReadData == 32'd3) begin found_k = c; break; end
    end
    bus_idle();
    check_val("search_found_cycle", 32'(found_k), 32'(199 + exp_n * NONCE_CYCLES));
    read_check("search_status", ADDR_STATUS, 32'd3);
    read_check("search_nonce", ADDR_NONCE, 32'(exp_n));
    dig = model_dsha(msg, 32'(exp_n));
    check_val("model_below_target", dig < tgt, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
